// File: rtl/sparse_pkg.sv
// Shared types and constants for the UART frame path: word width, sync marker, assembler states.
package sparse_pkg;

  localparam int          WORD_BYTES = 17;
  localparam int          WORD_W     = 8 * WORD_BYTES;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} rxf_state_t;

  typedef logic [WORD_W-1:0] word_t;

  function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/rx_frame_assembler_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is open, restarts on every received byte.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 868000
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int            TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMAX = '1;

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (!run || kick) begin
      timer_d = '0;
    end else if (timer_q != TMAX) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // A byte arriving on the last allowed cycle takes precedence over the timeout.
  assign expired = run && !kick && (timer_q == LAST);

endmodule

// File: rtl/rx_frame_assembler.sv
// Assembles SYNC + WORD_BYTES payload + XOR checksum from a UART byte stream into one memory word.
module rx_frame_assembler
  import sparse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 868000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       byte_valid,
  input  logic [7:0] rx_byte,
  output word_t      word_data,
  output logic       word_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int               CNT_W    = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

  rxf_state_t       state_q, state_d;
  word_t            shreg_q, shreg_d;
  word_t            word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       csum_q, csum_d;
  logic             word_valid_q, word_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             expired;

  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .run     (state_q != IDLE),
    .kick    (byte_valid),
    .expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    csum_d       = csum_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (byte_valid && rx_byte == SYNC_BYTE) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      PAYLOAD: begin
        // Sync-valued bytes here are plain data; there is no mid-frame resync.
        if (byte_valid) begin
          shreg_d = {shreg_q[WORD_W-9:0], rx_byte};
          csum_d  = csum_step(csum_q, rx_byte);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = CHECK;
          end
        end else if (expired) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      CHECK: begin
        if (byte_valid) begin
          state_d = IDLE;
          if (rx_byte == csum_q) begin
            word_d       = shreg_q;
            word_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (expired) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign word_data  = word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench: table of whole frames plus hand sequences for timeout, reset and back-to-back frames.
module tb_rx_frame_assembler;
  import sparse_pkg::*;

  localparam int TO = 24;

  // XOR of bytes 01..11 is 01 (01..0F cancel to 00, then ^10 ^11).
  localparam word_t W1   = 136'h0102030405060708090A0B0C0D0E0F1011;
  localparam word_t WREV = 136'h11100F0E0D0C0B0A090807060504030201;
  localparam word_t WFF  = {17{8'hFF}};
  localparam word_t WA5  = {17{8'hA5}};
  localparam word_t W5A  = 136'h5A;

  logic       clk = 1'b0;
  logic       resetn;
  logic       byte_valid;
  logic [7:0] rx_byte;
  word_t      word_data;
  logic       word_valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int both_hi  = 0;

  always #5 clk = ~clk;

  rx_frame_assembler #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .word_data  (word_data),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (word_valid && frame_err) both_hi++;
  end

  typedef struct packed {
    logic [1:0]  n_pre;
    logic [23:0] pre;
    word_t       pl;
    logic [7:0]  cs;
    logic        good;
    word_t       exp_word;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one cycle of input; returns at the negedge after the sampling posedge.
  task automatic drive(input logic v, input logic [7:0] b);
    byte_valid = v;
    rx_byte    = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input word_t pl, input logic [7:0] cs, output int pulses);
    word_t tmp;
    tmp    = pl;
    pulses = 0;
    drive(1'b1, SYNC_BYTE);
    for (int j = 0; j < WORD_BYTES; j++) begin
      drive(1'b1, tmp[WORD_W-1-8*j -: 8]);
      if (word_valid || frame_err) pulses++;
    end
    drive(1'b1, cs);
  endtask

  initial begin
    int    early;
    int    acc;
    word_t tmp;
    logic [23:0] pre;

    vecs[0] = '{n_pre: 2'd0, pre: 24'h0,      pl: W1,  cs: 8'h01, good: 1'b1, exp_word: W1};
    vecs[1] = '{n_pre: 2'd0, pre: 24'h0,      pl: W1,  cs: 8'h00, good: 1'b0, exp_word: W1};
    vecs[2] = '{n_pre: 2'd3, pre: 24'h00FF3C, pl: WFF, cs: 8'hFF, good: 1'b1, exp_word: WFF};
    vecs[3] = '{n_pre: 2'd0, pre: 24'h0,      pl: WA5, cs: 8'hA5, good: 1'b1, exp_word: WA5};
    vecs[4] = '{n_pre: 2'd0, pre: 24'h0,      pl: W1,  cs: 8'h11, good: 1'b0, exp_word: WA5};
    vecs[5] = '{n_pre: 2'd0, pre: 24'h0,      pl: W5A, cs: 8'h5A, good: 1'b1, exp_word: W5A};

    resetn     = 1'b0;
    byte_valid = 1'b0;
    rx_byte    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_word", word_data, '0);
    chk("rst_wv", word_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    drive(1'b0, 8'h00);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      pre = vecs[i].pre;
      tmp = vecs[i].pl;
      for (int p = 0; p < int'(vecs[i].n_pre); p++) begin
        drive(1'b1, pre[23-8*p -: 8]);
        chk($sformatf("v%0d_garbage_busy%0d", i, p), busy, 0);
      end
      drive(1'b1, SYNC_BYTE);
      chk($sformatf("v%0d_busy_after_sync", i), busy, 1);
      early = 0;
      for (int j = 0; j < WORD_BYTES; j++) begin
        drive(1'b1, tmp[WORD_W-1-8*j -: 8]);
        if (word_valid || frame_err || !busy) early++;
      end
      chk($sformatf("v%0d_payload_quiet", i), early, 0);
      drive(1'b1, vecs[i].cs);
      chk($sformatf("v%0d_wv", i), word_valid, vecs[i].good);
      chk($sformatf("v%0d_fe", i), frame_err, !vecs[i].good);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      chk($sformatf("v%0d_word", i), word_data, vecs[i].exp_word);
      drive(1'b0, 8'h00);
      chk($sformatf("v%0d_pulse_len", i), word_valid | frame_err, 0);
      $display("vector %0d done good=%0b word=%h", i, vecs[i].good, word_data);
    end

    // Stall after 5 payload bytes: error pulse TO cycles after the last strobe edge.
    drive(1'b1, SYNC_BYTE);
    for (int j = 1; j <= 5; j++) drive(1'b1, 8'(j));
    early = 0;
    acc   = 0;
    for (int j = 1; j <= TO; j++) begin
      drive(1'b0, 8'h00);
      if (j < TO) begin
        if (frame_err) early++;
        if (!busy) acc++;
      end
    end
    chk("stall_fe", frame_err, 1);
    chk("stall_busy_drop", busy, 0);
    chk("stall_no_early_fe", early, 0);
    chk("stall_busy_held", acc, 0);
    chk("stall_word_kept", word_data, W5A);
    drive(1'b0, 8'h00);
    chk("stall_fe_len", frame_err, 0);
    send_frame(W1, 8'h01, acc);
    chk("after_stall_wv", word_valid, 1);
    chk("after_stall_word", word_data, W1);
    $display("stall sequence done word=%h", word_data);

    // Byte on the last permitted idle cycle must keep the frame alive.
    drive(1'b0, 8'h00);
    tmp = WREV;
    drive(1'b1, SYNC_BYTE);
    for (int j = 0; j < 3; j++) drive(1'b1, tmp[WORD_W-1-8*j -: 8]);
    acc = 0;
    for (int j = 1; j < TO; j++) begin
      drive(1'b0, 8'h00);
      if (frame_err || !busy) acc++;
    end
    for (int j = 3; j < WORD_BYTES; j++) begin
      drive(1'b1, tmp[WORD_W-1-8*j -: 8]);
      if (frame_err) acc++;
    end
    chk("edge_no_timeout", acc, 0);
    drive(1'b1, 8'h01);
    chk("edge_wv", word_valid, 1);
    chk("edge_word", word_data, WREV);
    $display("timeout boundary sequence done word=%h", word_data);

    // Reset after 9 payload bytes.
    drive(1'b0, 8'h00);
    drive(1'b1, SYNC_BYTE);
    for (int j = 1; j <= 9; j++) drive(1'b1, 8'(j));
    byte_valid = 1'b0;
    resetn     = 1'b0;
    #1;
    chk("midrst_word", word_data, '0);
    chk("midrst_busy", busy, 0);
    acc = 0;
    repeat (3) begin
      @(negedge clk);
      if (word_valid || frame_err || busy) acc++;
    end
    resetn = 1'b1;
    drive(1'b0, 8'h00);
    chk("midrst_quiet", acc, 0);
    send_frame(W1, 8'h01, acc);
    chk("midrst_wv", word_valid, 1);
    chk("midrst_word_after", word_data, W1);
    $display("reset sequence done word=%h", word_data);

    // A5 payload, then next SYNC strobed on the word_valid cycle.
    drive(1'b0, 8'h00);
    send_frame(WA5, 8'hA5, acc);
    chk("b2b_first_wv", word_valid, 1);
    chk("b2b_first_word", word_data, WA5);
    send_frame(WREV, 8'h01, early);
    chk("b2b_quiet", acc + early, 0);
    chk("b2b_second_wv", word_valid, 1);
    chk("b2b_second_word", word_data, WREV);
    drive(1'b0, 8'h00);
    $display("back-to-back sequence done word=%h", word_data);

    chk("never_both_pulses", both_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
